// File: rtl/pipe_decoder.sv
// -----------------------------------------------------------------------------
// pipe_decoder
//   Decodes instructions at push time and buffers the decoded entries in a
//   DEPTH-entry FIFO. The head entry is presented on the outputs.
//
//   Handshake: a transfer happens on a rising clk edge when valid and ready
//   are both 1 on that side (in_valid/in_ready for push, out_valid/out_ready
//   for pop). in_ready and out_valid depend only on registered state, never
//   on the partner's valid/ready in the same cycle.
//
//   Parameters
//     REG_W   width of each register-address field (2..8)
//     DEPTH   FIFO entries, power of two (2..16)
//     INST_W  derived, 4 + 2*REG_W
//
//   Ports
//     clk        in   sole clock, rising edge
//     rst        in   synchronous active-high reset
//     inst       in   {op[3:0], rd[REG_W-1:0], rs[REG_W-1:0]}
//     in_valid   in   inst valid this cycle
//     in_ready   out  block can accept inst
//     out_valid  out  head entry valid
//     out_ready  in   consumer takes head entry
//     op         out  opcode of head entry
//     RegAddr    out  {rd, rs} of head entry
//     write, jump, mov, movReg, store, load   out  head-entry control flags
//     illegal    out  sticky illegal-opcode trap (0 unless trap enabled)
//     dec_count  out  number of entries popped, wraps at 16 bits
//
//   Build option
//     PIPE_DECODER_ILLEGAL_TRAP_EN  when defined, pushing an illegal opcode
//     sets a sticky illegal flag that blocks further pushes until rst; queued
//     entries still drain. When undefined, illegal opcodes pass through as
//     all-zero-flag entries and illegal is tied to 0.
// -----------------------------------------------------------------------------
module pipe_decoder #(
  parameter  int REG_W  = 6,
  parameter  int DEPTH  = 2,
  localparam int INST_W = 4 + 2 * REG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INST_W-1:0]    inst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           op,
  output logic [2*REG_W-1:0]   RegAddr,
  output logic                 write,
  output logic                 jump,
  output logic                 mov,
  output logic                 movReg,
  output logic                 store,
  output logic                 load,
  output logic                 illegal,
  output logic [15:0]          dec_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int FLAG_W  = 6;
  localparam int ENTRY_W = 4 + 2 * REG_W + FLAG_W;

  // Entry layout: {op, RegAddr, write, jump, mov, movReg, store, load}
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic [15:0]        r_dec_count;

  logic               w_push;
  logic               w_pop;
  logic               w_trap;
  logic [3:0]         w_op_in;
  logic [FLAG_W-1:0]  w_flags_in;
  logic [ENTRY_W-1:0] w_entry_in;
  logic [ENTRY_W-1:0] w_head;

  // ---------------------------------------------------------------------------
  // Decode (combinational, applied to the incoming instruction)
  // flags order: {write, jump, mov, movReg, store, load}
  // ---------------------------------------------------------------------------
  assign w_op_in = inst[INST_W-1 -: 4];

  always_comb begin
    w_flags_in = '0;
    case (w_op_in)
      4'h8:    w_flags_in = 6'b101000;  // mov
      4'h9:    w_flags_in = 6'b100100;  // movReg
      4'hA:    w_flags_in = 6'b100001;  // load
      4'hB:    w_flags_in = 6'b000010;  // store
      4'hC:    w_flags_in = 6'b010000;  // jump
      4'hD,
      4'hE,
      4'hF:    w_flags_in = 6'b000000;  // illegal: no flags, op kept
      default: w_flags_in = 6'b100000;  // 0..7 ALU
    endcase
  end

  assign w_entry_in = {inst, w_flags_in};

  // ---------------------------------------------------------------------------
  // Optional sticky illegal-opcode trap
  // ---------------------------------------------------------------------------
`ifdef PIPE_DECODER_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_dec_illegal;

  assign w_dec_illegal = (w_op_in >= 4'hD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_push && w_dec_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign w_trap = r_illegal;
`else
  assign w_trap = 1'b0;
`endif

  assign illegal = w_trap;

  // ---------------------------------------------------------------------------
  // Handshake. in_ready looks only at registered occupancy (and the trap), so
  // a full FIFO never accepts a push even when a pop happens the same cycle.
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_occ < OCC_W'(DEPTH)) && !w_trap;
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // FIFO storage: data needs no reset, validity is carried by r_occ
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_dec_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_dec_count <= r_dec_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs, forced to zero while nothing is queued
  // ---------------------------------------------------------------------------
  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

  assign op      = w_head[ENTRY_W-1 -: 4];
  assign RegAddr = w_head[FLAG_W +: 2*REG_W];
  assign write   = w_head[5];
  assign jump    = w_head[4];
  assign mov     = w_head[3];
  assign movReg  = w_head[2];
  assign store   = w_head[1];
  assign load    = w_head[0];

  assign dec_count = r_dec_count;

endmodule

// File: tb/tb_pipe_decoder.sv
// -----------------------------------------------------------------------------
// tb_pipe_decoder
//   Directed bench for pipe_decoder at default parameters. A reference model
//   (occupancy, pop counter, sticky trap, decode table) predicts handshakes and
//   pushes expected entries into exp_q when an instruction is accepted; the
//   head entry is compared against the popped expectation whenever a pop
//   happens.
// -----------------------------------------------------------------------------
module tb_pipe_decoder;

  localparam int REG_W   = 6;
  localparam int DEPTH   = 2;
  localparam int INST_W  = 4 + 2 * REG_W;
  localparam int ENTRY_W = 4 + 2 * REG_W + 6;
`ifdef PIPE_DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [INST_W-1:0]  inst      = '0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         op;
  logic [2*REG_W-1:0] RegAddr;
  logic               write, jump, mov, movReg, store, load;
  logic               illegal;
  logic [15:0]        dec_count;

  pipe_decoder #(.REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op        (op),
    .RegAddr   (RegAddr),
    .write     (write),
    .jump      (jump),
    .mov       (mov),
    .movReg    (movReg),
    .store     (store),
    .load      (load),
    .illegal   (illegal),
    .dec_count (dec_count)
  );

  // scoreboard and model state
  logic [ENTRY_W-1:0] exp_q[$];
  int                 occ_m = 0;
  logic [15:0]        cnt_m = '0;
  logic               ill_m = 1'b0;
  int                 n_checks = 0;
  int                 n_pass   = 0;

  function automatic logic [ENTRY_W-1:0] model_decode(input logic [INST_W-1:0] i);
    logic [3:0] o;
    logic w, j, m, mr, s, l;
    o = i[INST_W-1 -: 4];
    w = 1'b0; j = 1'b0; m = 1'b0; mr = 1'b0; s = 1'b0; l = 1'b0;
    if (o <= 4'd7) w = 1'b1;
    else if (o == 4'd8)  begin m  = 1'b1; w = 1'b1; end
    else if (o == 4'd9)  begin mr = 1'b1; w = 1'b1; end
    else if (o == 4'd10) begin l  = 1'b1; w = 1'b1; end
    else if (o == 4'd11) s = 1'b1;
    else if (o == 4'd12) j = 1'b1;
    return {o, i[2*REG_W-1:0], w, j, m, mr, s, l};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs after the falling edge, check the settled
  // outputs against the model, then advance the model for the coming edge.
  task automatic cycle(input logic v, input logic [INST_W-1:0] ins, input logic ordy);
    logic push_m, pop_m;
    logic [ENTRY_W-1:0] e;
    @(negedge clk);
    in_valid  = v;
    inst      = ins;
    out_ready = ordy;
    #1;
    chk("in_ready",  {31'd0, in_ready},  {31'd0, (occ_m < DEPTH) && !ill_m});
    chk("out_valid", {31'd0, out_valid}, {31'd0, occ_m != 0});
    chk("dec_count", {16'd0, dec_count}, {16'd0, cnt_m});
    chk("illegal",   {31'd0, illegal},   {31'd0, ill_m});
    push_m = v && (occ_m < DEPTH) && !ill_m;
    pop_m  = (occ_m != 0) && ordy;
    if (occ_m == 0)
      chk("idle_zero", 32'({op, RegAddr, write, jump, mov, movReg, store, load}), 32'd0);
    if (pop_m) begin
      e = exp_q.pop_front();
      chk("head", 32'({op, RegAddr, write, jump, mov, movReg, store, load}), 32'(e));
      cnt_m = cnt_m + 16'd1;
    end
    if (push_m) begin
      exp_q.push_back(model_decode(ins));
      if (TRAP && ins[INST_W-1 -: 4] >= 4'hD) ill_m = 1'b1;
    end
    occ_m = occ_m + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
  endtask

  // Hold rst for n edges while optionally offering a push and a pop.
  task automatic do_reset(input int n, input logic v, input logic ordy);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = v;
    inst      = 16'h4321;
    out_ready = ordy;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    occ_m    = 0;
    cnt_m    = '0;
    ill_m    = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // reset state
    do_reset(2, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("rst_dec_count", {16'd0, dec_count}, 32'd0);

    // decode table with out_ready=1
    cycle(1'b1, 16'h1000, 1'b1);
    cycle(1'b1, 16'h4001, 1'b1);
    cycle(1'b1, 16'h5001, 1'b1);
    cycle(1'b1, 16'h9001, 1'b1);
    cycle(1'b1, 16'hA001, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("decode_dec_count", {16'd0, dec_count}, 32'd5);

    // remaining opcodes, one each
    cycle(1'b1, 16'h8abc, 1'b1);
    cycle(1'b1, 16'hB123, 1'b1);
    cycle(1'b1, 16'hC7ff, 1'b1);
    cycle(1'b1, 16'h0fff, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // backpressure: third push held until space frees
    do_reset(1, 1'b0, 1'b0);
    cycle(1'b1, 16'h2041, 1'b0);
    cycle(1'b1, 16'h8082, 1'b0);
    cycle(1'b1, 16'hA0c3, 1'b0);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 16'hA0c3, 1'b1);
    cycle(1'b1, 16'hA0c3, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // full throughput: 20 back-to-back pushes
    do_reset(1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      cycle(1'b1, {4'($urandom_range(0, 12)), 12'($urandom_range(0, 4095))}, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("tput_dec_count", {16'd0, dec_count}, 32'd20);

    // random valid/ready with legal opcodes
    for (int k = 0; k < 40; k++)
      cycle(1'($urandom_range(0, 1)),
            {4'($urandom_range(0, 12)), 12'($urandom_range(0, 4095))},
            1'($urandom_range(0, 1)));
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);

    // illegal opcode, queued behind a legal entry
    do_reset(1, 1'b0, 1'b0);
    cycle(1'b1, 16'h4123, 1'b0);
    cycle(1'b1, 16'hE000, 1'b0);
    cycle(1'b1, 16'h1000, 1'b1);
    cycle(1'b1, 16'h1000, 1'b1);
    cycle(1'b1, 16'h3000, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("ill_flag", {31'd0, illegal}, {31'd0, TRAP});
    chk("ill_in_ready", {31'd0, in_ready}, {31'd0, !TRAP});

    // reset mid-stream, with push and pop offered during rst
    cycle(1'b1, 16'h5555, 1'b0);
    cycle(1'b1, 16'h6666, 1'b0);
    do_reset(1, 1'b1, 1'b1);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_dec_count", {16'd0, dec_count}, 32'd0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 16'h7001, 1'b1);
    cycle(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_decoder.md
PIPE_DECODER -- requirements
Module: pipe_decoder

Interface
REQ-001 SHALL have parameter REG_W, default 6, width of each register-address field; legal 2..8.
REQ-002 SHALL have parameter DEPTH, default 2, output-queue entries; power of two, 2..16.
REQ-003 SHALL derive INST_W = 4 + 2*REG_W, with default 16.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port inst  input  INST_W  instruction, laid out as op[INST_W-1:INST_W-4], rd next REG_W bits, rs low REG_W bits.
REQ-007 SHALL have port in_valid  input  1  inst is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block can accept inst.
REQ-009 SHALL have port out_valid  output  1  head entry is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head entry.
REQ-011 SHALL have port op  output  4  decoded opcode of the head entry.
REQ-012 SHALL have port RegAddr  output  2*REG_W  {rd, rs} of the head entry.
REQ-013 SHALL have ports write, jump, mov, movReg, store, load  output  1 each  head-entry control flags.
REQ-014 SHALL have port illegal  output  1  illegal-opcode indication; see REQ-030.
REQ-015 SHALL have port dec_count  output  16  count of entries popped.

Function
REQ-016 SHALL accept inst on a rising edge when in_valid and in_ready are both 1.
REQ-017 SHALL decode at push time and store op, RegAddr and all flags in a DEPTH-entry FIFO.
REQ-018 SHALL decode opcodes as follows: 0000-0111 ALU with write=1; 1000 mov with mov=1, write=1; 1001 movReg with movReg=1, write=1; 1010 load with load=1, write=1; 1011 store with store=1; 1100 jump with jump=1; 1101-1111 illegal.
REQ-019 SHALL assert at most one of jump, mov, movReg, store, load per entry.
REQ-020 SHALL pop the head entry on a rising edge when out_valid and out_ready are both 1.
REQ-021 SHALL drive in_ready = (occupancy < DEPTH) combinationally from registered occupancy, with no dependence on out_ready.
REQ-022 SHALL drive out_valid = (occupancy != 0).
REQ-023 SHALL have a latency of 1 cycle: an inst accepted at edge N appears at the outputs after edge N with the FIFO empty, and there is no same-cycle bypass.
REQ-024 SHALL sustain 1 entry/cycle when push and pop occur together and occupancy is between 1 and DEPTH-1; occupancy is then unchanged.
REQ-025 SHALL accept no push when full, even if a pop occurs in that same cycle.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL drive op, RegAddr and all flags to 0 while out_valid=0.
REQ-028 SHALL increment dec_count by 1 per pop, wrapping 0xFFFF to 0x0000.
REQ-029 SHALL decode an illegal opcode with all flags 0 and op preserved.

Reset
REQ-030 SHALL, when rst=1 at an edge, clear occupancy, pointers, dec_count and illegal; after that edge out_valid=0, in_ready=1 and all data outputs are 0.
REQ-031 SHALL give rst priority over a push or pop in the same cycle, discarding any entries mid-stream.

Configuration
REQ-032 SHALL support macro PIPE_DECODER_ILLEGAL_TRAP_EN.
REQ-033 SHALL, with the macro defined, set illegal sticky when an illegal opcode is pushed; while illegal=1, in_ready=0 and queued entries still drain, until rst.
REQ-034 SHALL, without the macro, tie illegal to 0 and pass illegal opcodes through as all-zero-flag entries (NOP).

Verification
REQ-035 SHALL verify reset: rst for 2 cycles -> out_valid=0, in_ready=1, dec_count=0, all flags 0.
REQ-036 SHALL verify decode at default params with out_ready=1: push 0x1000, 0x4001, 0x5001, 0x9001, 0xA001 -> write=1 for all, movReg=1 for 0x9001, load=1 for 0xA001, RegAddr=0x001 for the last four, dec_count=5.
REQ-037 SHALL verify backpressure with out_ready=0: push 3 insts at DEPTH=2 -> in_ready=0 after the 2nd push, the 3rd is held, out_ready=1 drains them in order.
REQ-038 SHALL verify full throughput: 20 back-to-back pushes with out_ready=1 -> one output per cycle after 1-cycle latency, dec_count=20.
REQ-039 SHALL verify illegal opcode: push 0xE000 -> with the macro, illegal=1 and in_ready stays 0 until rst; without the macro, an entry with all flags 0 and illegal=0.
REQ-040 SHALL verify reset mid-stream: 2 entries queued, assert rst -> next cycle out_valid=0 and dec_count=0.
